fifo_wr_arbiter: RTL and testbench

- Shares the single write port of one synchronous FIFO (DEPTH entries, DATA_WIDTH bits) among NUM_REQ producers.
- Producers are served by round-robin, burst-limited arbitration.
- The block tracks free FIFO slots with its own credit counter, so its registered write never overflows the FIFO.
- Sits directly in front of the FIFO's write side; the FIFO read side stays with the consumer, and the read handshake is mirrored back here as credit return.

---
 rtl/fifo_arb_pkg.sv | 23 ++
 rtl/rr_picker.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the FSM state encoding and the producer data slicer.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DW_MAX   = 64;
    localparam int NREQ_MAX = 8;
    // One spare slot keeps the variable part-select in range for any index.
    localparam int BUS_W    = (NREQ_MAX + 1) * DW_MAX;

    function automatic logic [DW_MAX-1:0] get_slice(
        input logic [BUS_W-1:0] bus,
        input int               idx,
        input int               dw
    );
        return bus[idx*dw +: DW_MAX];
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Scans upward from last+1 (modulo NUM_REQ) for the first active request.
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_last,
    output logic                       o_valid,
    output logic [$clog2(NUM_REQ)-1:0] o_winner
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int SW = OW + 1;

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [OW-1:0]        w_start;
    logic [SW-1:0]        w_sum;

    assign w_start = (i_last == OW'(NUM_REQ - 1)) ? '0 : i_last + 1'b1;
    assign w_dbl   = {i_req, i_req};
    assign w_rot   = w_dbl[w_start +: NUM_REQ];
    assign o_valid = |i_req;

    // Descending scan so the lowest rotated position wins.
    always_comb begin
        o_winner = '0;
        w_sum    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, w_start} + SW'(k);
                if (w_sum >= SW'(NUM_REQ)) begin
                    w_sum = w_sum - SW'(NUM_REQ);
                end
                o_winner = w_sum[OW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter for a shared FIFO write port.
// Tracks free FIFO slots with credits so a registered write never overflows.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int BURST_LEN  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            fifo_wt_en,
    output logic [DATA_WIDTH-1:0]           fifo_wdata,
    input  logic                            fifo_rd_en,
    input  logic                            fifo_empty,
    input  logic                            fifo_overflow,
    output logic [$clog2(NUM_REQ)-1:0]      owner,
    output logic [$clog2(DEPTH+1)-1:0]      credits,
    output logic                            err_overflow
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(BURST_LEN + 1);

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic [OW-1:0]         r_owner;
    logic [OW-1:0]         r_last;
    logic [BW-1:0]         r_beat;
    logic [CW-1:0]         r_credits;
    logic                  r_wt_en;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_err;

    logic                  w_pick_vld;
    logic [OW-1:0]         w_pick_idx;
    logic                  w_req_own;
    logic                  w_xfer;
    logic                  w_ret;
    logic                  w_ret_full;
    logic                  w_ret_ok;
    logic                  w_last_beat;
    logic                  w_release;
    logic [BUS_W-1:0]      w_bus;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req    (req),
        .i_last   (r_last),
        .o_valid  (w_pick_vld),
        .o_winner (w_pick_idx)
    );

    assign w_req_own   = req[r_owner];
    assign w_xfer      = (r_state == BURST) && w_req_own
                         && (r_credits != '0);
    assign w_ret       = fifo_rd_en && !fifo_empty;
    assign w_ret_full  = w_ret && (r_credits == CW'(DEPTH));
    assign w_ret_ok    = w_ret && !w_ret_full;
    assign w_last_beat = (r_beat == BW'(BURST_LEN - 1));
    assign w_release   = (r_state == BURST)
                         && (!w_req_own || (w_xfer && w_last_beat));

    always_comb begin
        w_bus = '0;
        w_bus[NUM_REQ*DATA_WIDTH-1:0] = req_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) w_state_nxt = BURST;
            end
            BURST: begin
                req_ready[r_owner] = w_xfer;
                if (w_release) w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_last  <= OW'(NUM_REQ - 1);
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_pick_vld) begin
                r_owner <= w_pick_idx;
                r_beat  <= '0;
            end else if (w_xfer) begin
                r_beat  <= r_beat + 1'b1;
            end
            if (w_release) r_last <= r_owner;
        end
    end

    // A return seen while already full is dropped and flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_credits <= CW'(DEPTH);
            r_err     <= 1'b0;
        end else begin
            if (w_xfer && !w_ret_ok) begin
                r_credits <= r_credits - 1'b1;
            end else if (!w_xfer && w_ret_ok) begin
                r_credits <= r_credits + 1'b1;
            end
            r_err <= r_err | fifo_overflow | w_ret_full;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wt_en <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_wt_en <= w_xfer;
            if (w_xfer) begin
                r_wdata <= DATA_WIDTH'(get_slice(w_bus, int'(r_owner),
                                                 DATA_WIDTH));
            end
        end
    end

    assign fifo_wt_en   = r_wt_en;
    assign fifo_wdata   = r_wdata;
    assign owner        = r_owner;
    assign credits      = r_credits;
    assign err_overflow = r_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with a transaction-level reference.
// Directed boundary scenarios followed by randomized traffic.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int D  = 16;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_wt_en;
    logic [DW-1:0]   fifo_wdata;
    logic            fifo_rd_en = 1'b0;
    logic            fifo_empty = 1'b1;
    logic            fifo_overflow = 1'b0;
    logic [1:0]      owner;
    logic [4:0]      credits;
    logic            err_overflow;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .DEPTH      (D),
        .BURST_LEN  (BL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_wt_en    (fifo_wt_en),
        .fifo_wdata    (fifo_wdata),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_empty    (fifo_empty),
        .fifo_overflow (fifo_overflow),
        .owner         (owner),
        .credits       (credits),
        .err_overflow  (err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } exp_t;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           n_wr    = 0;
    bit           m_busy;
    int           m_owner;
    int           m_last;
    int           m_beats;
    int           m_credits;
    bit           m_err;
    int           occ = 0;
    logic [N-1:0] last_dut_rdy = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            if (r[(last + i) % N]) return (last + i) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_busy    = 1'b0;
        m_owner   = 0;
        m_last    = N - 1;
        m_beats   = 0;
        m_credits = D;
        m_err     = 1'b0;
        occ       = 0;
        sb.delete();
    endtask

    // One clock: check at negedge, advance model, return at posedge+1.
    task automatic step();
        logic [N-1:0] er;
        bit           xf;
        bit           rt;
        int           c;
        int           on;
        @(negedge clk);
        er = '0;
        if (rst && m_busy && req[m_owner] && m_credits > 0) er[m_owner] = 1'b1;
        last_dut_rdy = req_ready;
        chk("req_ready", req_ready, er);
        chk("credits", credits, m_credits);
        chk("owner", owner, m_owner);
        chk("err_overflow", err_overflow, m_err);
        on = occ;
        if (rst) begin
            xf = (er != 0);
            rt = fifo_rd_en && !fifo_empty;
            if (xf) sb.push_back('{req_data[m_owner*DW +: DW], cyc + 1});
            c = m_credits;
            if (xf) c--;
            if (rt) begin
                if (m_credits == D) m_err = 1'b1;
                else c++;
            end
            if (fifo_overflow) m_err = 1'b1;
            m_credits = c;
            if (fifo_wt_en) on++;
            if (rt && occ > 0) on--;
            if (!m_busy) begin
                if (req != 0) begin
                    m_owner = pick(req, m_last);
                    m_beats = 0;
                    m_busy  = 1'b1;
                end
            end else if (!req[m_owner]) begin
                m_last = m_owner;
                m_busy = 1'b0;
            end else if (xf) begin
                m_beats++;
                if (m_beats == BL) begin
                    m_last = m_owner;
                    m_busy = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        occ = on;
        fifo_empty = (occ == 0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_wt_en", fifo_wt_en, 0);
        chk("rst_credits", credits, D);
        chk("rst_owner", owner, 0);
        chk("rst_err", err_overflow, 0);
        model_reset();
        fifo_empty = 1'b1;
        repeat (n) step();
        rst = 1'b1;
    endtask

    // Monitor: every DUT write must match the oldest expected beat in time.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (fifo_wt_en) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got data %0h expected none",
                             fifo_wdata);
                end else begin
                    e = sb.pop_front();
                    chk("wdata", fifo_wdata, e.d);
                    chk("write_cycle", cyc, e.c);
                    n_wr++;
                end
            end else if (sb.size() > 0 && sb[0].c <= cyc) begin
                e = sb.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missing_write: got none expected data %0h",
                         e.d);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int           w0;
        int           k;
        int           gap;
        int           rdp;
        bit           seen;
        logic [N-1:0] prev;
        int           order[$];
        int           exp_ord[4];

        exp_ord = '{0, 1, 3, 0};
        #2;
        req = 4'b1111;
        do_reset(3);
        req = '0;
        step();

        // Single producer, three beats.
        w0 = n_wr;
        req = 4'b0100;
        req_data[2*DW +: DW] = 8'hA0;
        k = 0;
        for (int i = 0; i < 20 && k < 3; i++) begin
            step();
            if (last_dut_rdy[2]) begin
                k++;
                req_data[2*DW +: DW] = 8'hA0 + 8'(k);
            end
            if (k == 3) req = '0;
        end
        repeat (3) step();
        chk("single_credits", credits, 13);
        chk("single_writes", n_wr - w0, 3);
        chk("single_owner", owner, 2);

        // Contention: grants rotate 0,1,3,0 with one idle cycle between.
        do_reset(1);
        fifo_rd_en = 1'b1;
        req = 4'b1011;
        prev = '0;
        gap = 0;
        for (int i = 0; i < 60 && order.size() < 4; i++) begin
            req_data = $urandom;
            step();
            if (last_dut_rdy != 0 && prev == 0) begin
                if (order.size() > 0) chk("grant_gap", gap, 1);
                order.push_back($clog2(last_dut_rdy));
                gap = 0;
            end else if (last_dut_rdy == 0) begin
                gap++;
            end
            prev = last_dut_rdy;
        end
        chk("grant_count", order.size(), 4);
        for (int i = 0; i < order.size() && i < 4; i++) begin
            chk("grant_order", order[i], exp_ord[i]);
        end
        req = '0;
        fifo_rd_en = 1'b0;
        repeat (3) step();

        // Credit exhaustion with no reads.
        do_reset(1);
        w0 = n_wr;
        req = 4'b0010;
        repeat (30) begin
            req_data = $urandom;
            step();
        end
        chk("exh_credits", credits, 0);
        chk("exh_writes", n_wr - w0, 16);
        chk("exh_ready", last_dut_rdy, 0);
        fifo_rd_en = 1'b1;
        step();
        fifo_rd_en = 1'b0;
        chk("exh_ret_credits", credits, 1);
        step();
        chk("exh_ret_ready", last_dut_rdy, 4'b0010);
        repeat (3) step();
        chk("exh_final_credits", credits, 0);
        chk("exh_final_writes", n_wr - w0, 17);
        req = '0;

        // Issue and return in the same cycle at credits=5.
        do_reset(1);
        req = 4'b0001;
        for (int i = 0; i < 40 && !(m_busy && m_credits == 5); i++) step();
        fifo_rd_en = 1'b1;
        step();
        fifo_rd_en = 1'b0;
        chk("simul_credits", credits, 5);
        req = '0;
        repeat (2) step();

        // Return while full, then an overflow pulse.
        do_reset(1);
        step();
        fifo_rd_en = 1'b1;
        fifo_empty = 1'b0;
        step();
        fifo_rd_en = 1'b0;
        chk("full_ret_credits", credits, 16);
        chk("full_ret_err", err_overflow, 1);
        step();
        do_reset(1);
        fifo_overflow = 1'b1;
        step();
        fifo_overflow = 1'b0;
        chk("ovf_err", err_overflow, 1);
        step();

        // Request drop after one beat records last=3.
        do_reset(1);
        fifo_rd_en = 1'b1;
        req = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (!m_busy && seen) break;
            seen |= m_busy;
        end
        req = 4'b1000;
        step();
        step();
        req = '0;
        step();
        chk("drop_owner", owner, 3);
        req = 4'b1111;
        step();
        step();
        chk("drop_regrant", last_dut_rdy, 4'b0001);

        // Reset in the middle of a burst.
        for (int i = 0; i < 10 && !(m_busy && m_beats >= 1); i++) step();
        do_reset(2);
        req = '0;
        step();

        // Randomized traffic with varying read pressure.
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) rdp = (i / 500) % 3 == 0 ? 10
                                  : (i / 500) % 3 == 1 ? 50 : 90;
            if ($urandom % 6 == 0) req = N'($urandom);
            req_data = $urandom;
            fifo_rd_en = ($urandom % 100) < rdp;
            step();
        end
        req = '0;
        fifo_rd_en = 1'b1;
        repeat (5) step();
        chk("sb_drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
